// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a byte-wide synchronous data memory.
// Handles bounds faults, little-endian halfword splitting and the memory's one-cycle read latency.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 50,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_half,
  input  logic              req_signed,
  input  logic [7:0]        req_base,
  input  logic [7:0]        req_offset,
  input  logic [15:0]       req_wdata,

  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_fault,

  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out
);

  localparam logic [9:0] LastAddr = 10'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccLo,
    StAccHi,
    StWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic              write_q;
  logic              half_q;
  logic              signed_q;
  logic              fault_q;
  logic [ADDR_W-1:0] ea_q;
  logic [15:0]       wdata_q;
  logic [7:0]        lo_q;
  logic [15:0]       rdata_q;

  logic              accept;
  logic [9:0]        ea_full;
  logic              fault_now;

  assign accept = req_valid & req_ready;

  // 10-bit two's-complement sum: range -128..382 fits, so bit 9 is a clean sign bit.
  assign ea_full   = {2'b00, req_base} + {{2{req_offset[7]}}, req_offset};
  assign fault_now = ea_full[9] | (ea_full > LastAddr) | (req_half & (ea_full >= LastAddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      half_q   <= 1'b0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      ea_q     <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        half_q   <= req_half;
        signed_q <= req_signed;
        fault_q  <= fault_now;
        ea_q     <= ea_full[ADDR_W-1:0];
        wdata_q  <= req_wdata;
        if (fault_now) begin
          rdata_q <= '0;
        end
      end
      // Low byte of a halfword load arrives while the high byte is being requested.
      if (state_q == StAccHi && !write_q) begin
        lo_q <= mem_data_out;
      end
      if (state_q == StWait) begin
        if (half_q) begin
          rdata_q <= {mem_data_out, lo_q};
        end else begin
          rdata_q <= {{8{signed_q & mem_data_out[7]}}, mem_data_out};
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = fault_now ? StDone : StAccLo;
        end
      end
      StAccLo: begin
        mem_address = ea_q;
        if (write_q) begin
          mem_write   = 1'b1;
          mem_data_in = wdata_q[7:0];
        end else begin
          mem_read = 1'b1;
        end
        if (half_q) begin
          state_d = StAccHi;
        end else begin
          state_d = write_q ? StDone : StWait;
        end
      end
      StAccHi: begin
        mem_address = ea_q + ADDR_W'(1);
        if (write_q) begin
          mem_write   = 1'b1;
          mem_data_in = wdata_q[15:8];
        end else begin
          mem_read = 1'b1;
        end
        state_d = write_q ? StDone : StWait;
      end
      StWait: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural memory image model, directed and random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_half, req_signed;
  logic [7:0]  req_base, req_offset;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_fault;
  logic [15:0] resp_rdata;
  logic        mem_write, mem_read;
  logic [5:0]  mem_address;
  logic [7:0]  mem_data_in, mem_data_out;

  load_store_unit #(
    .MEM_DEPTH(50),
    .ADDR_W   (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_half    (req_half),
    .req_signed  (req_signed),
    .req_base    (req_base),
    .req_offset  (req_offset),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Data memory the DUT talks to, with a preload port used only while in reset.
  logic [7:0] tb_mem [50];
  logic [7:0] ref_mem [50];
  logic [7:0] mem_rd;
  logic       pl_en;
  logic [5:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_addr] <= pl_data;
    else if (mem_write && mem_address < 6'd50) tb_mem[mem_address] <= mem_data_in;
    if (mem_read) mem_rd <= (mem_address < 6'd50) ? tb_mem[mem_address] : 8'h00;
  end
  assign mem_data_out = mem_rd;

  int          n_tests;
  int          n_fail;
  logic [15:0] exp_rdata;

  logic        nxt_write, nxt_half, nxt_signed;
  logic [7:0]  nxt_base, nxt_offset;
  logic [15:0] nxt_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to its response; entered and left just after a negedge.
  task automatic run_req(input logic w, input logic h, input logic s, input logic [7:0] b,
                         input logic [7:0] o, input logic [15:0] wd, input bit hold);
    int         ea, lat_exp, nw, nr, exp_nw, exp_nr;
    int         exp_addr [2];
    logic [7:0] exp_wd [2];
    logic [7:0] byt;
    logic       flt;
    bit         done;

    ea = int'(b) + int'($signed(o));
    flt = (ea < 0) || (ea > 49) || (h && (ea + 1 > 49));
    exp_addr[0] = ea;
    exp_addr[1] = ea + 1;
    exp_wd[0] = wd[7:0];
    exp_wd[1] = wd[15:8];
    if (flt) begin
      lat_exp = 1; exp_nw = 0; exp_nr = 0;
      exp_rdata = 16'h0000;
    end else if (w) begin
      lat_exp = h ? 3 : 2; exp_nw = h ? 2 : 1; exp_nr = 0;
      ref_mem[ea] = wd[7:0];
      if (h) ref_mem[ea + 1] = wd[15:8];
    end else begin
      lat_exp = h ? 4 : 3; exp_nw = 0; exp_nr = h ? 2 : 1;
      if (h) exp_rdata = {ref_mem[ea + 1], ref_mem[ea]};
      else begin
        byt = ref_mem[ea];
        exp_rdata = s ? {{8{byt[7]}}, byt} : {8'h00, byt};
      end
    end

    @(negedge clk);
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_write = w; req_half = h; req_signed = s;
    req_base = b; req_offset = o; req_wdata = wd;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    nw = 0; nr = 0; done = 0;
    for (int lat = 1; lat <= 8 && !done; lat++) begin
      @(negedge clk);
      if (lat == 1) begin
        req_valid = hold;
        if (hold) begin
          req_write = nxt_write; req_half = nxt_half; req_signed = nxt_signed;
          req_base = nxt_base; req_offset = nxt_offset; req_wdata = nxt_wdata;
        end else begin
          req_write = 1'($urandom); req_half = 1'($urandom); req_signed = 1'($urandom);
          req_base = 8'($urandom); req_offset = 8'($urandom); req_wdata = 16'($urandom);
        end
      end
      check("strobe_excl", {31'd0, mem_write & mem_read}, 32'd0);
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (mem_write) begin
        if (nw < 2) begin
          check("wr_addr", {26'd0, mem_address}, exp_addr[nw]);
          check("wr_data", {24'd0, mem_data_in}, {24'd0, exp_wd[nw]});
        end
        nw++;
      end
      if (mem_read) begin
        if (nr < 2) check("rd_addr", {26'd0, mem_address}, exp_addr[nr]);
        nr++;
      end
      if (resp_valid) begin
        done = 1;
        check("latency", lat, lat_exp);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
        check("resp_rdata", {16'd0, resp_rdata}, {16'd0, exp_rdata});
      end
    end
    check("resp_seen", {31'd0, done}, 32'd1);
    check("n_writes", nw, exp_nw);
    check("n_reads", nr, exp_nr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_rdata = 16'h0000;
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0; req_signed = 1'b0;
    req_base = '0; req_offset = '0; req_wdata = '0;
    nxt_write = 1'b0; nxt_half = 1'b0; nxt_signed = 1'b0;
    nxt_base = '0; nxt_offset = '0; nxt_wdata = '0;

    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", {16'd0, resp_rdata}, 32'd0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_addr", {26'd0, mem_address}, 32'd0);

    pl_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      pl_addr = 6'(i);
      pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst_n = 1'b1;

    // Byte store then signed and unsigned byte loads at ea = 10 - 3.
    run_req(1'b1, 1'b0, 1'b0, 8'd10, 8'hFD, 16'h00A5, 1'b0);
    run_req(1'b0, 1'b0, 1'b1, 8'd10, 8'hFD, 16'h0000, 1'b0);
    check("plan_sext", {16'd0, resp_rdata}, 32'h0000FFA5);
    run_req(1'b0, 1'b0, 1'b0, 8'd10, 8'hFD, 16'h0000, 1'b0);
    check("plan_zext", {16'd0, resp_rdata}, 32'h000000A5);

    // Halfword store then load at 20.
    run_req(1'b1, 1'b1, 1'b0, 8'd20, 8'd0, 16'h1234, 1'b0);
    check("rdata_hold_store", {16'd0, resp_rdata}, 32'h000000A5);
    run_req(1'b0, 1'b1, 1'b1, 8'd20, 8'd0, 16'h0000, 1'b0);
    check("plan_half", {16'd0, resp_rdata}, 32'h00001234);

    // Bounds.
    run_req(1'b0, 1'b1, 1'b0, 8'd49, 8'd0, 16'h0000, 1'b0);
    run_req(1'b0, 1'b0, 1'b0, 8'd49, 8'd0, 16'h0000, 1'b0);
    run_req(1'b1, 1'b0, 1'b0, 8'd2, 8'hFB, 16'h00EE, 1'b0);
    run_req(1'b1, 1'b0, 1'b0, 8'd255, 8'd1, 16'h00EE, 1'b0);
    run_req(1'b1, 1'b1, 1'b0, 8'd48, 8'd0, 16'hBEEF, 1'b0);

    // Back-to-back with req_valid held: B is presented while A is still in flight.
    nxt_write = 1'b0; nxt_half = 1'b1; nxt_signed = 1'b0;
    nxt_base = 8'd40; nxt_offset = 8'd2; nxt_wdata = 16'hFFFF;
    run_req(1'b1, 1'b1, 1'b0, 8'd40, 8'd2, 16'hC3D4, 1'b1);
    run_req(1'b0, 1'b1, 1'b0, 8'd40, 8'd2, 16'hFFFF, 1'b0);

    // Reset while a halfword load is in its high-byte access.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_half = 1'b1; req_signed = 1'b0;
    req_base = 8'd30; req_offset = 8'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hi_read", {31'd0, mem_read}, 32'd1);
    check("hi_addr", {26'd0, mem_address}, 32'd31);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
    check("mid_rst_rdata", {16'd0, resp_rdata}, 32'd0);
    check("mid_rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("mid_rst_addr", {18'd0, mem_address, mem_data_in}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
    run_req(1'b0, 1'b0, 1'b1, 8'd30, 8'd0, 16'h0000, 1'b0);

    // Random mix, biased towards the legal window and its edges.
    for (int k = 0; k < 150; k++) begin
      logic [7:0] rb, ro;
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 55));
      ro = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8) - 4);
      run_req(1'($urandom), 1'($urandom), 1'($urandom), rb, ro, 16'($urandom), 1'b0);
    end

    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("mem_image", {24'd0, tb_mem[i]}, {24'd0, ref_mem[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
